data_memory_mmio: RTL and testbench
===================================

# data_memory_mmio

Data-side responder for the single-cycle MIPS core: answers the core's `data_memory_*` port with a word-addressed RAM plus a small memory-mapped I/O window. The window holds a byte-wide console transmit FIFO with a valid/ready drain port, a free-running cycle counter and a store counter. It sits between the core's data port and the testbench/debug sink, replacing a bare RAM model.

## Interface
- `DEPTH`, 1024: RAM size in 32-bit words; power of 2.
- `FIFO_DEPTH`, 8: console FIFO entries; power of 2, ≥2.
- `clk` input 1: single clock, all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `data_memory_a` input 32: byte address from the core.
- `data_memory_we` input 1: store strobe, sampled at posedge.
- `data_memory_wd` input 32: store data.
- `data_memory_rd` output 32: load data, combinational from `data_memory_a`.
- `cons_data` output 8: FIFO head byte.
- `cons_valid` output 1: FIFO non-empty.
- `cons_ready` input 1: sink accepts `cons_data` at posedge when `cons_valid`.
- `align_err` output 1: sticky misaligned-store flag (see Configuration).

## Operation
- Address decode, checked in order:
  - RAM: `a < DEPTH*4`; word index `a[log2(DEPTH)+1:2]`.
  - `0xFFFF_0000` CONS_DATA: write pushes `wd[7:0]`; read returns 0.
  - `0xFFFF_0004` CONS_STATUS: read `{drop_cnt[15:0], level[7:0], 6'b0, full, empty}`; write with `wd[0]=1` clears `drop_cnt`.
  - `0xFFFF_0008` CYCLE: read the counter; write loads `wd`.
  - `0xFFFF_000C` STORES: read-only count of accepted RAM stores.
  - Anything else: read 0, write ignored.
- RAM store: `mem[idx] <= wd` at posedge when `we`. Increments STORES (32-bit, wraps).
- Console push: accepted when not full, or when full with a pop in the same cycle. Otherwise the byte is dropped and `drop_cnt` increments, saturating at 0xFFFF.
- Pop occurs on `cons_valid & cons_ready`.
- `level` ranges 0..FIFO_DEPTH. Push and pop in the same cycle leave `level` unchanged.
- Read/write pointers wrap modulo FIFO_DEPTH.
- `full = (level == FIFO_DEPTH)`, `empty = (level == 0)`.
- CYCLE increments by 1 every non-reset cycle, wrapping 0xFFFF_FFFF→0. A write loads `wd` in place of that cycle's increment.

## Timing
- Loads: zero latency, combinational. Load of a location stored in the same cycle returns the old value; the new value is visible from the next cycle.
- Stores and MMIO writes take effect at the posedge where `we=1`.
- Push to an empty FIFO: `cons_valid` rises the cycle after the push edge, with `cons_data` equal to the pushed byte.
- `cons_data` is stable while `cons_valid & !cons_ready`.
- CONS_STATUS and STORES reads reflect register state before the current edge.
- A CYCLE read in the cycle after loading value V returns V. It returns V+1 one cycle later.
- Reset (synchronous, dominates everything in that cycle):
  - FIFO emptied, so `cons_valid=0` and `level=0`.
  - `drop_cnt`, CYCLE, STORES and `align_err` cleared to 0.
  - Any store or push presented during reset is ignored.
  - RAM contents are not cleared.
  - A mid-stream reset discards queued bytes; no pop is reported to the sink.
- After reset: `data_memory_rd` is a function of address only; `cons_data` is don't-care while `cons_valid=0`.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - A store with `a[1:0] != 0` is suppressed: no RAM write, no MMIO effect, no STORES increment.
  - `align_err` sets at that edge and holds until reset.
  - Loads are unaffected (low bits ignored).
- `DMEM_ALIGN_CHECK_EN` undefined: `a[1:0]` is ignored for all accesses, and `align_err` is tied to 0.

## Test plan
- RAM store/load: store 0x1234_5678 at 0x10, then 0xCAFE_F00D at 0x14. Loads return those values next cycle; a same-cycle load of 0x10 during the store returns the old content. STORES reads 2.
- Console backpressure: `cons_ready=0`, push 'A'..'I' (9 bytes, FIFO_DEPTH=8). STATUS reads full=1, level=8, drop_cnt=1. Then hold `cons_ready=1`: sink sees 'A'..'H' in order, one per cycle, and `cons_valid` falls after 'H'.
- Full push+pop: FIFO full and `cons_ready=1`, push 'Z'. The push is accepted, level stays 8, drop_cnt unchanged, and 'Z' is the last byte out.
- Counters: write CYCLE=0xFFFF_FFFE. Reads return 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0x0000_0000 on consecutive cycles. Write STATUS `wd=1`: drop_cnt reads 0.
- Reset mid-operation: with 3 bytes queued and a store to 0x20 presented, assert `reset` for one cycle. `cons_valid=0`, STATUS reads 0x0000_0001, CYCLE restarts at 0, and RAM[0x20] is unchanged.
- Alignment (macro defined): store 0xAAAA_AAAA to 0x22. RAM[0x20] is unchanged, `align_err=1` next cycle and stays set, STORES is unchanged. Without the macro, the same store writes RAM[0x20] and `align_err` stays 0.

Source files
------------

// File: rtl/data_memory_mmio_if.sv
// Core data-port and console-drain signals between the MIPS core side and data_memory_mmio.
// The master side drives address/store/ready; the memory answers with load data and the console head byte.
interface data_memory_mmio_if;
  logic [31:0] data_memory_a;
  logic        data_memory_we;
  logic [31:0] data_memory_wd;
  logic [31:0] data_memory_rd;
  logic [7:0]  cons_data;
  logic        cons_valid;
  logic        cons_ready;

  modport master (
    output data_memory_a, data_memory_we, data_memory_wd, cons_ready,
    input  data_memory_rd, cons_data, cons_valid
  );

  modport slave (
    input  data_memory_a, data_memory_we, data_memory_wd, cons_ready,
    output data_memory_rd, cons_data, cons_valid
  );
endinterface

// File: rtl/data_memory_mmio.sv
// Word RAM plus MMIO (console FIFO, cycle and store counters); loads combinational, writes at posedge, full FIFO drops unless popped.
// DMEM_ALIGN_CHECK_EN: suppress misaligned stores and raise sticky align_err.
module data_memory_mmio #(
  parameter int DEPTH      = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  data_memory_mmio_if.slave  bus,
  output logic               align_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int LW = FW + 1;

  localparam logic [29:0] W_CONS_DATA = 30'h3FFF_C000;
  localparam logic [29:0] W_CONS_STAT = 30'h3FFF_C001;
  localparam logic [29:0] W_CYCLE     = 30'h3FFF_C002;
  localparam logic [29:0] W_STORES    = 30'h3FFF_C003;

  logic [31:0]   r_mem  [DEPTH];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [FW-1:0] r_rp;
  logic [FW-1:0] r_wp;
  logic [LW-1:0] r_level;
  logic [15:0]   r_drop;
  logic [31:0]   r_cycle;
  logic [31:0]   r_stores;

  logic          w_ram_hit;
  logic [AW-1:0] w_idx;
  logic [29:0]   w_word;
  logic          w_sel_cons, w_sel_stat, w_sel_cycle;
  logic          w_we;
  logic          w_full, w_empty;
  logic          w_pop, w_push_req, w_push, w_drop;
  logic [7:0]    w_level8;
  logic [31:0]   w_rd;

  assign w_ram_hit   = (bus.data_memory_a[31:AW+2] == '0);
  assign w_idx       = bus.data_memory_a[AW+1:2];
  assign w_word      = bus.data_memory_a[31:2];
  assign w_sel_cons  = (w_word == W_CONS_DATA);
  assign w_sel_stat  = (w_word == W_CONS_STAT);
  assign w_sel_cycle = (w_word == W_CYCLE);

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_align_err;
  logic w_mis;
  assign w_mis     = (bus.data_memory_a[1:0] != 2'b00);
  assign w_we      = bus.data_memory_we & ~w_mis;
  assign align_err = r_align_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_align_err <= 1'b0;
    end else if (bus.data_memory_we && w_mis) begin
      r_align_err <= 1'b1;
    end
  end
`else
  logic w_unused_lo;
  assign w_unused_lo = ^bus.data_memory_a[1:0];
  assign w_we        = bus.data_memory_we;
  assign align_err   = 1'b0;
`endif

  assign w_full     = (r_level == LW'(FIFO_DEPTH));
  assign w_empty    = (r_level == '0);
  assign w_pop      = ~w_empty & bus.cons_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign w_push_req = w_we & w_sel_cons;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & ~w_push;
  assign w_level8   = 8'(r_level);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rp     <= '0;
      r_wp     <= '0;
      r_level  <= '0;
      r_drop   <= '0;
      r_cycle  <= '0;
      r_stores <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + FW'(1);
      if (w_pop)  r_rp <= r_rp + FW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_we && w_sel_stat && bus.data_memory_wd[0]) begin
        r_drop <= '0;
      end else if (w_drop && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end
      r_cycle <= (w_we && w_sel_cycle) ? bus.data_memory_wd : r_cycle + 32'd1;
      if (w_we && w_ram_hit) r_stores <= r_stores + 32'd1;
    end
  end

  // Storage arrays carry no reset; reset only blocks writes in that cycle.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_fifo[r_wp] <= bus.data_memory_wd[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset && w_we && w_ram_hit) r_mem[w_idx] <= bus.data_memory_wd;
  end

  always_comb begin
    w_rd = '0;
    if (w_ram_hit) begin
      w_rd = r_mem[w_idx];
    end else if (w_sel_stat) begin
      w_rd = {r_drop, w_level8, 6'b0, w_full, w_empty};
    end else if (w_sel_cycle) begin
      w_rd = r_cycle;
    end else if (w_word == W_STORES) begin
      w_rd = r_stores;
    end
  end

  assign bus.data_memory_rd = w_rd;
  assign bus.cons_data      = r_fifo[r_rp];
  assign bus.cons_valid     = ~w_empty;
endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed bench for data_memory_mmio: inputs change on negedge, outputs sampled 1ns later.
module tb_data_memory_mmio;
  localparam logic [31:0] A_CONS   = 32'hFFFF_0000;
  localparam logic [31:0] A_STAT   = 32'hFFFF_0004;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0008;
  localparam logic [31:0] A_STORES = 32'hFFFF_000C;

  logic clk;
  logic reset;
  logic align_err;
  int   checks;
  int   errors;

  data_memory_mmio_if bus ();

  data_memory_mmio #(.DEPTH(1024), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .align_err (align_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.data_memory_a  = a;
    bus.data_memory_we = 1'b1;
    bus.data_memory_wd = d;
    @(negedge clk);
    bus.data_memory_we = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    bus.data_memory_a = A_STAT;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== 32'h0000_0001) begin errors++; $display("FAIL reset_status got %h exp %h", rd, 32'h1); end
    checks++;
    if (bus.cons_valid !== 1'b0) begin errors++; $display("FAIL reset_cons_valid got %b exp 0", bus.cons_valid); end
    checks++;
    if (align_err !== 1'b0) begin errors++; $display("FAIL reset_align_err got %b exp 0", align_err); end
    bus.data_memory_a = A_STORES;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_stores got %h exp 0", rd); end
    bus.data_memory_a = A_CYCLE;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_cycle got %h exp 0", rd); end
  endtask

  task automatic test_ram();
    logic [31:0] rd;
    @(negedge clk);
    bus.data_memory_a  = 32'h10;
    bus.data_memory_we = 1'b1;
    bus.data_memory_wd = 32'h1234_5678;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== 32'h1111_1111) begin errors++; $display("FAIL ram_same_cycle got %h exp %h", rd, 32'h1111_1111); end
    @(negedge clk);
    bus.data_memory_a  = 32'h14;
    bus.data_memory_wd = 32'hCAFE_F00D;
    @(negedge clk);
    bus.data_memory_we = 1'b0;
    bus.data_memory_a  = 32'h10;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== 32'h1234_5678) begin errors++; $display("FAIL ram_load_10 got %h exp %h", rd, 32'h1234_5678); end
    bus.data_memory_a = 32'h14;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_load_14 got %h exp %h", rd, 32'hCAFE_F00D); end
    bus.data_memory_a = A_STORES;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== 32'd2) begin errors++; $display("FAIL ram_stores got %0d exp 2", rd); end
    // First address past the RAM must neither alias word 0 nor count as a store.
    store(32'h0000_1000, 32'h5555_5555);
    bus.data_memory_a = 32'h0;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL ram_no_alias got %h exp 0", rd); end
    bus.data_memory_a = 32'h0000_1000;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 0", rd); end
    bus.data_memory_a = A_STORES;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== 32'd2) begin errors++; $display("FAIL unmapped_stores got %0d exp 2", rd); end
  endtask

  task automatic test_console_backpressure();
    logic [31:0] rd;
    bus.cons_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.data_memory_a  = A_CONS;
      bus.data_memory_we = 1'b1;
      bus.data_memory_wd = 32'h41 + 32'(i);
    end
    @(negedge clk);
    bus.data_memory_we = 1'b0;
    bus.data_memory_a  = A_STAT;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== 32'h0001_0802) begin errors++; $display("FAIL bp_status_full got %h exp %h", rd, 32'h0001_0802); end
    bus.data_memory_a = A_CONS;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL cons_data_read got %h exp 0", rd); end
    @(negedge clk);
    bus.cons_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (bus.cons_valid !== 1'b1 || bus.cons_data !== 8'(8'h41 + k)) begin
        errors++;
        $display("FAIL bp_drain_%0d got v=%b d=%h exp v=1 d=%h", k, bus.cons_valid, bus.cons_data, 8'(8'h41 + k));
      end
      @(negedge clk);
    end
    bus.data_memory_a = A_STAT;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (bus.cons_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_fall got %b exp 0", bus.cons_valid); end
    checks++;
    if (rd !== 32'h0001_0001) begin errors++; $display("FAIL bp_status_empty got %h exp %h", rd, 32'h0001_0001); end
    bus.cons_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] rd;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.data_memory_a  = A_CONS;
      bus.data_memory_we = 1'b1;
      bus.data_memory_wd = 32'h61 + 32'(i);
    end
    @(negedge clk);
    bus.cons_ready     = 1'b1;
    bus.data_memory_wd = 32'h5A;
    @(negedge clk);
    bus.data_memory_we = 1'b0;
    bus.data_memory_a  = A_STAT;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== 32'h0001_0802) begin errors++; $display("FAIL fpp_status got %h exp %h", rd, 32'h0001_0802); end
    for (int k = 0; k < 8; k++) begin
      logic [7:0] exp_b;
      exp_b = (k == 7) ? 8'h5A : 8'(8'h62 + k);
      #1;
      checks++;
      if (bus.cons_valid !== 1'b1 || bus.cons_data !== exp_b) begin
        errors++;
        $display("FAIL fpp_drain_%0d got v=%b d=%h exp v=1 d=%h", k, bus.cons_valid, bus.cons_data, exp_b);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (bus.cons_valid !== 1'b0) begin errors++; $display("FAIL fpp_valid_fall got %b exp 0", bus.cons_valid); end
    bus.cons_ready = 1'b0;
  endtask

  task automatic test_counters();
    logic [31:0] rd;
    logic [31:0] exp_c [3];
    exp_c[0] = 32'hFFFF_FFFE;
    exp_c[1] = 32'hFFFF_FFFF;
    exp_c[2] = 32'h0000_0000;
    store(A_CYCLE, 32'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      #1 rd = bus.data_memory_rd;
      checks++;
      if (rd !== exp_c[k]) begin errors++; $display("FAIL cycle_%0d got %h exp %h", k, rd, exp_c[k]); end
      @(negedge clk);
    end
    store(A_STAT, 32'h1);
    bus.data_memory_a = A_STAT;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== 32'h0000_0001) begin errors++; $display("FAIL drop_clear got %h exp %h", rd, 32'h1); end
    store(A_STORES, 32'h55);
    bus.data_memory_a = A_STORES;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== 32'd2) begin errors++; $display("FAIL stores_readonly got %h exp 2", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.data_memory_a  = A_CONS;
      bus.data_memory_we = 1'b1;
      bus.data_memory_wd = 32'h31 + 32'(i);
    end
    @(negedge clk);
    reset              = 1'b1;
    bus.data_memory_a  = 32'h20;
    bus.data_memory_wd = 32'hDEAD_BEEF;
    @(negedge clk);
    reset              = 1'b0;
    bus.data_memory_we = 1'b0;
    bus.data_memory_a  = A_CYCLE;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_cycle got %h exp 0", rd); end
    checks++;
    if (bus.cons_valid !== 1'b0) begin errors++; $display("FAIL rst_cons_valid got %b exp 0", bus.cons_valid); end
    bus.data_memory_a = A_STAT;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== 32'h0000_0001) begin errors++; $display("FAIL rst_status got %h exp %h", rd, 32'h1); end
    bus.data_memory_a = 32'h20;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== 32'h2222_2222) begin errors++; $display("FAIL rst_ram_kept got %h exp %h", rd, 32'h2222_2222); end
    @(negedge clk);
    bus.data_memory_a = A_CYCLE;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL rst_cycle_next got %h exp 1", rd); end
  endtask

  task automatic test_align();
    logic [31:0] rd;
    logic [31:0] exp_ram;
    logic [31:0] exp_st;
    logic        exp_err;
`ifdef DMEM_ALIGN_CHECK_EN
    exp_ram = 32'h2222_2222;
    exp_st  = 32'd0;
    exp_err = 1'b1;
`else
    exp_ram = 32'hAAAA_AAAA;
    exp_st  = 32'd1;
    exp_err = 1'b0;
`endif
    store(32'h22, 32'hAAAA_AAAA);
    bus.data_memory_a = 32'h20;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== exp_ram) begin errors++; $display("FAIL align_ram got %h exp %h", rd, exp_ram); end
    checks++;
    if (align_err !== exp_err) begin errors++; $display("FAIL align_err got %b exp %b", align_err, exp_err); end
    bus.data_memory_a = A_STORES;
    #1 rd = bus.data_memory_rd;
    checks++;
    if (rd !== exp_st) begin errors++; $display("FAIL align_stores got %h exp %h", rd, exp_st); end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (align_err !== exp_err) begin errors++; $display("FAIL align_err_hold got %b exp %b", align_err, exp_err); end
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    reset              = 1'b1;
    bus.data_memory_a  = '0;
    bus.data_memory_we = 1'b0;
    bus.data_memory_wd = '0;
    bus.cons_ready     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    // Seed known RAM contents, then reset so counters restart (RAM survives reset).
    store(32'h00, 32'h0000_0000);
    store(32'h10, 32'h1111_1111);
    store(32'h20, 32'h2222_2222);
    pulse_reset();
    test_ram();
    test_console_backpressure();
    test_full_push_pop();
    test_counters();
    test_reset_mid();
    test_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
